pwm_multi_controller: RTL and testbench

Parametrised multi-channel PWM generator driving the motor-speed outputs of the FPGA controller. Each channel takes a narrow speed code and scales it to a CNT_W-bit duty by bit replication, so code 0 gives 0 % and full scale gives 100 %. Duty writes go into a shadow register and are applied only at the period boundary, so pulses never glitch. An optional soft-start ramp limits how fast the duty can change per period.

---
 rtl/pwm_multi_controller.sv | 155 +++++++++++++++
 tb/tb_pwm_multi_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_controller.sv
// -----------------------------------------------------------------------------
// pwm_multi_controller
//
// Multi-channel PWM generator for the motor-speed outputs. Each channel takes
// an IN_W-bit speed code and expands it to a CNT_W-bit duty by replicating the
// code, so code 0 is 0 % and full-scale is 100 %. Writes land in a shadow
// register and reach the active compare value only at the period boundary,
// so a pulse is never cut short or stretched mid-period.
//
// Optional feature (compile-time macro PWM_RAMP_EN):
//   defined   - at each boundary the active duty moves toward the shadow value
//               by at most RAMP_STEP counts (soft start / soft stop).
//   undefined - at each boundary the active duty takes the shadow value as is.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   wr_en        in   one-cycle write strobe for a channel's speed code
//   wr_ch        in   channel index of the write (indices >= CHANNELS ignored)
//   wr_duty      in   speed code
//   ch_en        in   per-channel enable (level)
//   pwm_out      out  registered PWM outputs
//   period_start out  one-clk pulse marking the start of each PWM period
//   ramp_busy    out  some enabled channel's active duty differs from target
// -----------------------------------------------------------------------------
module pwm_multi_controller #(
   parameter int CHANNELS  = 2,
   parameter int CNT_W     = 8,
   parameter int IN_W      = 4,
   parameter int PRESCALE  = 1,
   parameter int RAMP_STEP = 17,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [IN_W-1:0]     wr_duty,
   input  logic [CHANNELS-1:0] ch_en,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_start,
   output logic                ramp_busy
);

   localparam int REP  = CNT_W / IN_W;
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
   // Last counter value of a period is MAX-1; the counter never holds MAX.
   localparam logic [CNT_W-1:0] LAST    = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]   STEP    = (CNT_W+1)'(RAMP_STEP);
   localparam logic [CH_W:0]    CH_LIM  = (CH_W+1)'(CHANNELS);

   // Replicating the code maps 0 -> 0 and all-ones -> all-ones exactly.
   function automatic logic [CNT_W-1:0] scale_code(input logic [IN_W-1:0] code);
      return {REP{code}};
   endfunction

   // One ramp step toward tgt, done one bit wider than the duty so the gap
   // comparison can never wrap; the step is only added when it stays short
   // of the target, so the result saturates at tgt.
   function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                    input logic [CNT_W-1:0] tgt);
      logic [CNT_W:0]   cur_x;
      logic [CNT_W:0]   tgt_x;
      logic [CNT_W-1:0] nxt;
      cur_x = {1'b0, cur};
      tgt_x = {1'b0, tgt};
      if (tgt_x > cur_x) begin
         if ((tgt_x - cur_x) > STEP) nxt = cur + STEP[CNT_W-1:0];
         else                        nxt = tgt;
      end else begin
         if ((cur_x - tgt_x) > STEP) nxt = cur - STEP[CNT_W-1:0];
         else                        nxt = tgt;
      end
      return nxt;
   endfunction

   logic [PS_W-1:0]                psc_q, psc_d;
   logic [CNT_W-1:0]               count_q, count_d;
   logic [CHANNELS-1:0][CNT_W-1:0] shadow_q, shadow_d;
   logic [CHANNELS-1:0][CNT_W-1:0] active_q, active_d;
   logic [CHANNELS-1:0]            pwm_q, pwm_d;
   logic                           ps_q, ps_d;
   logic                           busy_q, busy_d;
   logic                           tick_s;
   logic                           boundary_s;
   logic                           wr_valid_s;

   // Next-state logic: prescaler, period counter, shadow/active duties, outputs.
   always_comb begin
      tick_s     = (psc_q == PS_LAST);
      boundary_s = tick_s && (count_q == LAST);
      wr_valid_s = wr_en && ({1'b0, wr_ch} < CH_LIM);

      if (tick_s) psc_d = '0;
      else        psc_d = psc_q + PS_ONE;

      if (!tick_s)         count_d = count_q;
      else if (boundary_s) count_d = '0;
      else                 count_d = count_q + CNT_ONE;

      ps_d   = boundary_s;
      busy_d = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_d[i] = ch_en[i] && (count_q < active_q[i]);
         busy_d   = busy_d | (ch_en[i] && (active_q[i] != shadow_q[i]));

         if (wr_valid_s && (wr_ch == CH_W'(i))) shadow_d[i] = scale_code(wr_duty);
         else                                   shadow_d[i] = shadow_q[i];

         // Disable beats the boundary update; a re-enabled channel idles at 0
         // until the next boundary, so no partial pulse appears.
         if (!ch_en[i]) begin
            active_d[i] = '0;
         end else if (boundary_s) begin
`ifdef PWM_RAMP_EN
            active_d[i] = ramp_toward(active_q[i], shadow_q[i]);
`else
            active_d[i] = shadow_q[i];
`endif
         end else begin
            active_d[i] = active_q[i];
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         psc_q    <= '0;
         count_q  <= '0;
         shadow_q <= '0;
         active_q <= '0;
         pwm_q    <= '0;
         ps_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         psc_q    <= psc_d;
         count_q  <= count_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
         ps_q     <= ps_d;
         busy_q   <= busy_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = ps_q;
   assign ramp_busy    = busy_q;

endmodule

// File: tb/tb_pwm_multi_controller.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_controller
//
// Two instances share the stimulus: dut0 (2 channels, PRESCALE=1) and dut1
// (3 channels, PRESCALE=4, so a 2-bit wr_ch can address a missing channel).
// A reference model computes every output from the period arithmetic
// (clks since reset, period length MAX*PRESCALE, high while the phase is
// below active*PRESCALE) and is compared every cycle; a table of duty
// writes and hand-written sequences add fixed expected values.
// -----------------------------------------------------------------------------
module tb_pwm_multi_controller;

   localparam int MAXV  = 255;
   localparam int RSTEP = 17;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [1:0] wr_ch;
   logic [3:0] wr_duty;
   logic [2:0] ch_en;
   logic [1:0] pwm0;
   logic       ps0, busy0;
   logic [2:0] pwm1;
   logic       ps1, busy1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int pp [2] = '{1, 4};
   int nc [2] = '{2, 3};
   int m_k  [2];
   int m_sh [2][3];
   int m_ac [2][3];
   logic [2:0] m_pwm  [2];
   logic       m_ps   [2];
   logic       m_busy [2];

   typedef struct {
      int ch;
      int code;
      int exp_high;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;

   pwm_multi_controller #(.CHANNELS(2), .CNT_W(8), .IN_W(4), .PRESCALE(1), .RAMP_STEP(RSTEP)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch[0:0]), .wr_duty(wr_duty),
      .ch_en(ch_en[1:0]), .pwm_out(pwm0), .period_start(ps0), .ramp_busy(busy0)
   );

   pwm_multi_controller #(.CHANNELS(3), .CNT_W(8), .IN_W(4), .PRESCALE(4), .RAMP_STEP(RSTEP)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
      .ch_en(ch_en), .pwm_out(pwm1), .period_start(ps1), .ramp_busy(busy1)
   );

   function automatic int ramp_ref(input int a, input int s);
      int r;
`ifdef PWM_RAMP_EN
      if (s > a) r = (a + RSTEP < s) ? a + RSTEP : s;
      else       r = (a - RSTEP > s) ? a - RSTEP : s;
`else
      r = (a == s) ? a : s;
`endif
      return r;
   endfunction

   // Advance the model of instance d by one clk edge using the current inputs.
   task automatic model_edge(input int d);
      logic [2:0] en;
      int         ch;
      int         per;
      bit         bnd;
      logic       busy;
      en = ch_en;
      if (d == 0) en[2] = 1'b0;
      ch = (d == 0) ? int'(wr_ch[0]) : int'(wr_ch);
      if (rst) begin
         m_k[d] = 0;
         for (int i = 0; i < 3; i++) begin
            m_sh[d][i] = 0;
            m_ac[d][i] = 0;
         end
         m_pwm[d]  = 3'b000;
         m_ps[d]   = 1'b0;
         m_busy[d] = 1'b0;
      end else begin
         per = pp[d] * MAXV;
         m_k[d] += 1;
         bnd  = ((m_k[d] % per) == 0);
         busy = 1'b0;
         m_pwm[d] = 3'b000;
         for (int i = 0; i < nc[d]; i++) begin
            m_pwm[d][i] = en[i] && (((m_k[d] - 1) % per) < m_ac[d][i] * pp[d]);
            if (en[i] && (m_ac[d][i] != m_sh[d][i])) busy = 1'b1;
         end
         m_ps[d]   = bnd;
         m_busy[d] = busy;
         for (int i = 0; i < nc[d]; i++) begin
            if (!en[i])   m_ac[d][i] = 0;
            else if (bnd) m_ac[d][i] = ramp_ref(m_ac[d][i], m_sh[d][i]);
         end
         if (wr_en && (ch < nc[d])) m_sh[d][ch] = int'(wr_duty) * 17;
      end
   endtask

   task automatic step();
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
      cyc++;
      total++;
      if ({1'b0, pwm0, ps0, busy0} !== {m_pwm[0], m_ps[0], m_busy[0]}) begin
         bad++;
         $display("FAIL cycle_dut0 cyc=%0d got pwm=%b ps=%b busy=%b want pwm=%b ps=%b busy=%b",
                  cyc, pwm0, ps0, busy0, m_pwm[0][1:0], m_ps[0], m_busy[0]);
      end
      total++;
      if ({pwm1, ps1, busy1} !== {m_pwm[1], m_ps[1], m_busy[1]}) begin
         bad++;
         $display("FAIL cycle_dut1 cyc=%0d got pwm=%b ps=%b busy=%b want pwm=%b ps=%b busy=%b",
                  cyc, pwm1, ps1, busy1, m_pwm[1], m_ps[1], m_busy[1]);
      end
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic write(input int ch, input int code);
      wr_en   = 1'b1;
      wr_ch   = 2'(ch);
      wr_duty = 4'(code);
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_ps0();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((ps0 !== 1'b1) && (n < 1100));
      if (ps0 !== 1'b1) expect_int("wait_period_start_timeout", 0, 1);
   endtask

   task automatic wait_busy0_low();
      int n;
      n = 0;
      while ((busy0 !== 1'b0) && (n < 5000)) begin
         step();
         n++;
      end
      if (busy0 !== 1'b0) expect_int("wait_ramp_busy_low_timeout", 0, 1);
   endtask

   // Highs of dut0 channel ch over one full period that starts now.
   task automatic count_period(input int ch, output int highs);
      highs = 0;
      for (int n = 0; n < MAXV; n++) begin
         step();
         highs += int'(pwm0[ch]);
      end
   endtask

   // Highs of dut0 channel ch until (and including) the next boundary.
   task automatic finish_period(input int ch, output int highs);
      int n;
      highs = 0;
      n = 0;
      do begin
         step();
         highs += int'(pwm0[ch]);
         n++;
      end while ((ps0 !== 1'b1) && (n < 300));
      if (ps0 !== 1'b1) expect_int("finish_period_timeout", 0, 1);
   endtask

   initial begin
      int h;
      int first0, second0, first1;
      int ramp_on;
      int idx;

`ifdef PWM_RAMP_EN
      ramp_on = 1;
`else
      ramp_on = 0;
`endif

      vecs[0] = '{0, 8, 136};
      vecs[1] = '{1, 3, 51};
      vecs[2] = '{0, 0, 0};
      vecs[3] = '{0, 15, 255};
      vecs[4] = '{1, 10, 170};
      vecs[5] = '{0, 1, 17};

      rst = 1'b1; wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 4'd0; ch_en = 3'b111;
      step(); step(); step();
      expect_int("reset_pwm0", int'(pwm0), 0);
      expect_int("reset_ps0", int'(ps0), 0);
      expect_int("reset_busy0", int'(busy0), 0);
      expect_int("reset_pwm1", int'(pwm1), 0);
      rst = 1'b0;

      // Duty scaling table: settled high time per period.
      for (int r = 0; r < 6; r++) begin
         write(vecs[r].ch, vecs[r].code);
         step(); step();
         wait_busy0_low();
         wait_ps0();
         count_period(vecs[r].ch, h);
         expect_int($sformatf("duty_ch%0d_code%0h", vecs[r].ch, vecs[r].code), h, vecs[r].exp_high);
      end

      // Reset in mid-period, then first boundary timing for both instances.
      write(0, 15);
      step(); step();
      wait_busy0_low();
      wait_ps0();
      repeat (50) step();
      expect_int("pre_reset_high", int'(pwm0[0]), 1);
      rst = 1'b1;
      step();
      expect_int("rst_mid_pwm0", int'(pwm0), 0);
      expect_int("rst_mid_ps0", int'(ps0), 0);
      rst = 1'b0;
      first0 = -1; second0 = -1; first1 = -1;
      for (int n = 1; n <= 1100; n++) begin
         step();
         if (ps0 === 1'b1) begin
            if (first0 < 0)       first0 = n;
            else if (second0 < 0) second0 = n;
         end
         if ((ps1 === 1'b1) && (first1 < 0)) first1 = n;
      end
      expect_int("first_period_start_dut0", first0, 255);
      expect_int("period_spacing_dut0", second0 - first0, 255);
      expect_int("first_period_start_prescale4", first1, 1020);

      // Glitch-free update: write at count=100 leaves the current period alone.
      wait_ps0();
      repeat (100) step();
      write(1, 3);
      finish_period(1, h);
      expect_int("glitch_current_period", h, 0);
      count_period(1, h);
      expect_int("glitch_next_period", h, (ramp_on != 0) ? 17 : 51);
      repeat (10) step();
      write(1, 5);
      write(1, 2);
      finish_period(1, h);
      count_period(1, h);
      expect_int("last_write_wins", h, 34);

      // Disable and re-enable.
      write(0, 10);
      step(); step();
      wait_busy0_low();
      wait_ps0();
      repeat (5) step();
      expect_int("pre_disable_high", int'(pwm0[0]), 1);
      ch_en[0] = 1'b0;
      step();
      expect_int("disable_next_clk", int'(pwm0[0]), 0);
      repeat (20) step();
      ch_en[0] = 1'b1;
      finish_period(0, h);
      expect_int("reenable_no_partial", h, 0);
      count_period(0, h);
      expect_int("reenable_first_period", h, (ramp_on != 0) ? 17 : 170);

      // Ramp from 0 to full scale.
      rst = 1'b1;
      step();
      rst = 1'b0;
      write(0, 15);
      wait_ps0();
      for (int p = 1; p <= 15; p++) begin
         count_period(0, h);
         expect_int($sformatf("ramp_period_%0d", p), h,
                    (ramp_on != 0) ? ((17 * p < 255) ? 17 * p : 255) : 255);
         if (p == 7) expect_int("ramp_busy_mid", int'(busy0), ramp_on);
      end
      step(); step();
      expect_int("ramp_busy_done", int'(busy0), 0);

      // Channel index guard on the 3-channel instance.
      rst = 1'b1;
      step();
      rst = 1'b0;
      write(3, 15);
      step(); step(); step();
      expect_int("guard_invalid_index", int'(busy1), 0);
      write(2, 15);
      step(); step();
      expect_int("guard_valid_index", int'(busy1), 1);

      // Randomized traffic, checked every cycle against the model.
      for (int n = 0; n < 6000; n++) begin
         wr_en   = ($urandom_range(0, 29) == 0);
         wr_ch   = 2'($urandom_range(0, 3));
         wr_duty = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) begin
            idx = int'($urandom_range(0, 2));
            ch_en[idx] = ~ch_en[idx];
         end
         rst = ($urandom_range(0, 2999) == 0);
         step();
      end
      rst = 1'b0;
      wr_en = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
